// File: rtl/usb_token_decoder.sv
// USB token packet decoder: validates OUT/IN/SETUP/SOF tokens from the receiver byte
// stream and produces the transaction-start strobe, endpoint selection and SOF frame number.
module usb_token_decoder #(
  parameter int EP_COUNT = 16
) (
  input  logic        clk12_i,
  input  logic        rst_i,
  input  logic [6:0]  deviceAddr_i,
  input  logic        rxDataValid_i,
  input  logic [7:0]  rxData_i,
  input  logic        rxIsLastByte_i,
  input  logic        rxError_i,
  output logic        gotTransStartPacket_o,
  output logic [1:0]  transStartTokenID_o,
  output logic [3:0]  transStartEndpoint_o,
  output logic        targetsEpIN_o,
  output logic        sofValid_o,
  output logic [10:0] frameNumber_o,
  output logic        tokenDropped_o,
  output logic [2:0]  fsmState_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    ENDP    = 3'd2,
    TRAIL   = 3'd3,
    DISCARD = 3'd4
  } state_t;

  localparam logic [1:0] PID_SOF  = 2'b01;
  localparam logic [1:0] PID_IN   = 2'b10;
  localparam logic [4:0] EP_LIMIT = 5'(EP_COUNT);
  localparam logic [4:0] CRC_RESIDUAL = 5'b01100;

  state_t     state;
  state_t     stateNext;
  logic [1:0] pidReg;
  logic [6:0] addrReg;
  logic       ep0Reg;

  logic        pidCheckOk;
  logic        pidIsToken;
  logic [3:0]  epCand;
  logic [15:0] crcField;
  logic        crcOk;
  logic        tokenNext;
  logic        sofNext;
  logic        dropNext;

  // Residual CRC5 over the whole field, LSB first; a clean packet leaves 01100.
  function automatic logic [4:0] crc5Residual(input logic [15:0] d);
    logic [4:0] c;
    logic       fb;
    c = 5'b11111;
    for (int i = 0; i < 16; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return c;
  endfunction

  assign pidCheckOk = (rxData_i[7:4] == ~rxData_i[3:0]);
  assign pidIsToken = (rxData_i[1:0] == 2'b01);
  assign epCand     = {rxData_i[2:0], ep0Reg};
  assign crcField   = {rxData_i, ep0Reg, addrReg};
  assign crcOk      = (crc5Residual(crcField) == CRC_RESIDUAL);
  assign fsmState_o = state;

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (rxError_i) begin
      stateNext = IDLE;
    end else if (rxDataValid_i) begin
      case (state)
        IDLE: begin
          if (rxIsLastByte_i)                  stateNext = IDLE;
          else if (!pidCheckOk || !pidIsToken) stateNext = DISCARD;
          else                                 stateNext = ADDR;
        end
        ADDR:    stateNext = rxIsLastByte_i ? IDLE : ENDP;
        ENDP:    stateNext = rxIsLastByte_i ? IDLE : TRAIL;
        TRAIL:   stateNext = rxIsLastByte_i ? IDLE : DISCARD;
        DISCARD: stateNext = rxIsLastByte_i ? IDLE : DISCARD;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Pulse decisions for the byte seen this cycle; they become visible one cycle later.
  always_comb begin
    tokenNext = 1'b0;
    sofNext   = 1'b0;
    dropNext  = 1'b0;
    if (rxError_i) begin
      dropNext = (state == ADDR) || (state == ENDP) || (state == TRAIL);
    end else if (rxDataValid_i) begin
      case (state)
        IDLE:  dropNext = pidCheckOk && pidIsToken && rxIsLastByte_i;
        ADDR:  dropNext = rxIsLastByte_i;
        ENDP: begin
          if (rxIsLastByte_i) begin
            if (pidReg == PID_SOF) begin
              sofNext  = crcOk;
              dropNext = !crcOk;
            end else if (crcOk && (addrReg == deviceAddr_i) && ({1'b0, epCand} < EP_LIMIT)) begin
              tokenNext = 1'b1;
            end else begin
              dropNext = 1'b1;
            end
          end
        end
        TRAIL:   dropNext = 1'b1;
        default: dropNext = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      pidReg  <= 2'b00;
      addrReg <= 7'd0;
      ep0Reg  <= 1'b0;
    end else if (rxDataValid_i && !rxError_i) begin
      if (state == IDLE) pidReg <= rxData_i[3:2];
      if (state == ADDR) begin
        addrReg <= rxData_i[6:0];
        ep0Reg  <= rxData_i[7];
      end
    end
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      gotTransStartPacket_o <= 1'b0;
      sofValid_o            <= 1'b0;
      tokenDropped_o        <= 1'b0;
      transStartTokenID_o   <= 2'b00;
      transStartEndpoint_o  <= 4'd0;
      targetsEpIN_o         <= 1'b0;
      frameNumber_o         <= 11'd0;
    end else begin
      gotTransStartPacket_o <= tokenNext;
      sofValid_o            <= sofNext;
      tokenDropped_o        <= dropNext;
      if (tokenNext) begin
        transStartTokenID_o  <= pidReg;
        transStartEndpoint_o <= epCand;
        targetsEpIN_o        <= (pidReg == PID_IN);
      end
      if (sofNext) begin
        frameNumber_o <= {epCand, addrReg};
      end
    end
  end

endmodule

// File: tb/tb_usb_token_decoder.sv
// Directed bench for usb_token_decoder: token decode, SOF, validation drops,
// receiver errors and mid-packet reset.
`timescale 1ns/1ps
module tb_usb_token_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  deviceAddr;
  logic        rxDataValid;
  logic [7:0]  rxData;
  logic        rxIsLastByte;
  logic        rxError;
  logic        gotTransStartPacket;
  logic [1:0]  transStartTokenID;
  logic [3:0]  transStartEndpoint;
  logic        targetsEpIN;
  logic        sofValid;
  logic [10:0] frameNumber;
  logic        tokenDropped;
  logic [2:0]  fsmState;

  int evaluated = 0;
  int failures  = 0;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [7:0] PID_SETUP = 8'h2D;

  usb_token_decoder #(.EP_COUNT(4)) dut (
    .clk12_i               (clk),
    .rst_i                 (rst),
    .deviceAddr_i          (deviceAddr),
    .rxDataValid_i         (rxDataValid),
    .rxData_i              (rxData),
    .rxIsLastByte_i        (rxIsLastByte),
    .rxError_i             (rxError),
    .gotTransStartPacket_o (gotTransStartPacket),
    .transStartTokenID_o   (transStartTokenID),
    .transStartEndpoint_o  (transStartEndpoint),
    .targetsEpIN_o         (targetsEpIN),
    .sofValid_o            (sofValid),
    .frameNumber_o         (frameNumber),
    .tokenDropped_o        (tokenDropped),
    .fsmState_o            (fsmState)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Transmitted CRC5 field for 11 data bits: inverted remainder, MSB of remainder first on wire.
  function automatic logic [4:0] crc5Field(input logic [10:0] d);
    logic [4:0] c;
    logic [4:0] f;
    logic       fb;
    c = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    for (int j = 0; j < 5; j++) f[j] = ~c[4-j];
    return f;
  endfunction

  function automatic logic [15:0] tokenBody(input logic [6:0] addr, input logic [3:0] endp,
                                            input logic flipCrc);
    logic [4:0] crc;
    crc = crc5Field({endp, addr});
    if (flipCrc) crc[2] = ~crc[2];
    return {crc, endp, addr};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkPulses(input string tag, input logic got, input logic sof, input logic drop);
    check({tag, ".got"},  16'(gotTransStartPacket), 16'(got));
    check({tag, ".sof"},  16'(sofValid),            16'(sof));
    check({tag, ".drop"}, 16'(tokenDropped),        16'(drop));
  endtask

  task automatic checkHeld(input string tag, input logic [1:0] id, input logic [3:0] ep,
                           input logic isIn);
    check({tag, ".id"}, 16'(transStartTokenID),  16'(id));
    check({tag, ".ep"}, 16'(transStartEndpoint), 16'(ep));
    check({tag, ".in"}, 16'(targetsEpIN),        16'(isIn));
  endtask

  // driver tasks: each call occupies exactly one clock cycle
  task automatic drive(input logic [7:0] d, input logic last, input logic err);
    rxDataValid  = 1'b1;
    rxData       = d;
    rxIsLastByte = last;
    rxError      = err;
    @(posedge clk); #1;
    rxDataValid  = 1'b0;
    rxIsLastByte = 1'b0;
    rxError      = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic sendToken(input logic [7:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                           input logic flipCrc, input int gap);
    logic [15:0] body;
    body = tokenBody(addr, endp, flipCrc);
    drive(pid, 1'b0, 1'b0);
    repeat (gap) idle();
    drive(body[7:0], 1'b0, 1'b0);
    repeat (gap) idle();
    drive(body[15:8], 1'b1, 1'b0);
  endtask

  initial begin
    logic [15:0] body;
    rst = 1'b1; deviceAddr = 7'h15;
    rxDataValid = 1'b0; rxData = 8'h00; rxIsLastByte = 1'b0; rxError = 1'b0;
    repeat (3) idle();
    rst = 1'b0;
    idle();
    checkPulses("reset", 1'b0, 1'b0, 1'b0);
    checkHeld("reset", 2'b00, 4'd0, 1'b0);
    check("reset.frame", 16'(frameNumber), 16'h000);
    check("reset.state", 16'(fsmState), 16'd0);

    // IN to 0x15 endpoint 1, with gaps between bytes
    sendToken(PID_IN, 7'h15, 4'd1, 1'b0, 2);
    checkPulses("in1", 1'b1, 1'b0, 1'b0);
    checkHeld("in1", 2'b10, 4'd1, 1'b1);
    idle();
    checkPulses("in1.after", 1'b0, 1'b0, 1'b0);
    checkHeld("in1.after", 2'b10, 4'd1, 1'b1);

    // SETUP then OUT back-to-back, device address 0
    deviceAddr = 7'h00;
    sendToken(PID_SETUP, 7'h00, 4'd0, 1'b0, 0);
    checkPulses("setup", 1'b1, 1'b0, 1'b0);
    checkHeld("setup", 2'b11, 4'd0, 1'b0);
    body = tokenBody(7'h00, 4'd2, 1'b0);
    drive(PID_OUT, 1'b0, 1'b0);
    checkPulses("out.pid", 1'b0, 1'b0, 1'b0);
    drive(body[7:0], 1'b0, 1'b0);
    drive(body[15:8], 1'b1, 1'b0);
    checkPulses("out", 1'b1, 1'b0, 1'b0);
    checkHeld("out", 2'b00, 4'd2, 1'b0);

    // validation failures against deviceAddr 0x15 with EP_COUNT 4
    deviceAddr = 7'h15;
    sendToken(PID_IN, 7'h15, 4'd1, 1'b1, 0);
    checkPulses("badcrc", 1'b0, 1'b0, 1'b1);
    checkHeld("badcrc", 2'b00, 4'd2, 1'b0);
    sendToken(PID_IN, 7'h16, 4'd1, 1'b0, 0);
    checkPulses("badaddr", 1'b0, 1'b0, 1'b1);
    sendToken(PID_IN, 7'h15, 4'd5, 1'b0, 0);
    checkPulses("badep", 1'b0, 1'b0, 1'b1);
    checkHeld("badep", 2'b00, 4'd2, 1'b0);
    idle();
    checkPulses("badep.after", 1'b0, 1'b0, 1'b0);

    // SOF frame 0x5A3 = endp 0xB, addr 0x23
    sendToken(PID_SOF, 7'h23, 4'hB, 1'b0, 0);
    checkPulses("sof", 1'b0, 1'b1, 1'b0);
    check("sof.frame", 16'(frameNumber), 16'h5A3);
    checkHeld("sof", 2'b00, 4'd2, 1'b0);
    idle();
    checkPulses("sof.after", 1'b0, 1'b0, 1'b0);
    check("sof.frameHeld", 16'(frameNumber), 16'h5A3);

    // DATA0 packet, 4 bytes
    drive(8'hC3, 1'b0, 1'b0);
    drive(8'h15, 1'b0, 1'b0);
    drive(8'h80, 1'b0, 1'b0);
    drive(8'h00, 1'b1, 1'b0);
    checkPulses("data0", 1'b0, 1'b0, 1'b0);
    check("data0.state", 16'(fsmState), 16'd0);

    // bad PID check nibble, body of a valid IN token following
    body = tokenBody(7'h15, 4'd1, 1'b0);
    drive(8'h68, 1'b0, 1'b0);
    drive(body[7:0], 1'b0, 1'b0);
    drive(body[15:8], 1'b1, 1'b0);
    checkPulses("badpid", 1'b0, 1'b0, 1'b0);

    // 4-byte IN
    drive(PID_IN, 1'b0, 1'b0);
    drive(body[7:0], 1'b0, 1'b0);
    drive(body[15:8], 1'b0, 1'b0);
    checkPulses("long.b2", 1'b0, 1'b0, 1'b0);
    drive(8'h00, 1'b1, 1'b0);
    checkPulses("long", 1'b0, 1'b0, 1'b1);

    // 2-byte IN
    drive(PID_IN, 1'b0, 1'b0);
    drive(body[7:0], 1'b1, 1'b0);
    checkPulses("short", 1'b0, 1'b0, 1'b1);
    checkHeld("short", 2'b00, 4'd2, 1'b0);

    // receiver error on the last byte of a valid IN, then a valid OUT
    drive(PID_IN, 1'b0, 1'b0);
    drive(body[7:0], 1'b0, 1'b0);
    drive(body[15:8], 1'b1, 1'b1);
    checkPulses("rxerr", 1'b0, 1'b0, 1'b1);
    check("rxerr.state", 16'(fsmState), 16'd0);
    sendToken(PID_OUT, 7'h15, 4'd3, 1'b0, 0);
    checkPulses("rxerr.out", 1'b1, 1'b0, 1'b0);
    checkHeld("rxerr.out", 2'b00, 4'd3, 1'b0);

    // reset after byte 1 clears everything, next token decodes
    drive(PID_IN, 1'b0, 1'b0);
    drive(body[7:0], 1'b0, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checkPulses("rst", 1'b0, 1'b0, 1'b0);
    checkHeld("rst", 2'b00, 4'd0, 1'b0);
    check("rst.frame", 16'(frameNumber), 16'h000);
    check("rst.state", 16'(fsmState), 16'd0);
    sendToken(PID_IN, 7'h15, 4'd1, 1'b0, 0);
    checkPulses("rst.in", 1'b1, 1'b0, 1'b0);
    checkHeld("rst.in", 2'b10, 4'd1, 1'b1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
